// File: rtl/gold_code_gen_mc.sv
// Multi-channel Gold code generator.
// One shared LFSR A is XORed with NUM_CH individually seeded LFSR B instances.
// The channels share a chip counter, so the codes stay chip-aligned on a
// common epoch. Seeds are written over a valid/ready port while the FSM is idle.
// Optional feature macro: GOLD_PERIOD_CHECK_EN enables a sticky check that
// LFSR A is all-ones exactly at chip 0.
module gold_code_gen_mc #(
  parameter int                N        = 63,
  parameter int                LENGTH   = $clog2(N + 1),
  parameter logic [LENGTH-1:0] POLY_A   = 6'b100001,
  parameter logic [LENGTH-1:0] POLY_B   = 6'b110011,
  parameter int                NUM_CH   = 4,
  parameter int                CHIP_DIV = 1,
  localparam int               CW       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int               DW       = (CHIP_DIV > 1) ? $clog2(CHIP_DIV) : 1
) (
  input  logic              clkin,
  input  logic              rstn,
  input  logic              cfg_valid_i,
  output logic              cfg_ready_o,
  input  logic [CW-1:0]     cfg_ch_i,
  input  logic [LENGTH-1:0] cfg_seed_i,
  input  logic              start_i,
  input  logic              stop_i,
  output logic [NUM_CH-1:0] code_gold_o,
  output logic              code_valid_o,
  output logic              epoch_o,
  output logic [LENGTH-1:0] chip_idx_o,
  output logic              err_o
);

  typedef enum logic [1:0] {S_IDLE, S_ARM, S_RUN} state_e;

  localparam logic [LENGTH-1:0] ONES = '1;

  // One Fibonacci step: shift toward MSB, parity of tapped bits enters bit 0.
  function automatic logic [LENGTH-1:0] lfsr_step(input logic [LENGTH-1:0] s,
                                                  input logic [LENGTH-1:0] p);
    return {s[LENGTH-2:0], ^(s & p)};
  endfunction

  state_e            state_q;
  logic [LENGTH-1:0] a_q;
  logic [LENGTH-1:0] cnt_q;      // index of the next chip to emit
  logic [DW-1:0]     div_q;
  logic              stop_pend_q;
  logic [LENGTH-1:0] seed_q [NUM_CH];
  logic [LENGTH-1:0] b_q    [NUM_CH];
  logic [NUM_CH-1:0] gold_arm_d;
  logic [NUM_CH-1:0] gold_tick_d;

  logic cfg_wr;
  logic tick;
  logic arm;
  logic run_tick;
  logic stop_req;

  assign cfg_wr   = cfg_valid_i & cfg_ready_o;
  assign tick     = (div_q == DW'(CHIP_DIV - 1));
  assign arm      = (state_q == S_ARM);
  assign run_tick = (state_q == S_RUN) && tick;
  assign stop_req = stop_i | stop_pend_q;

  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
      // Seed store: a zero seed would lock the LFSR, so it is stored as 1.
      // Channel numbers past NUM_CH match no entry and are silently dropped.
      always_ff @(posedge clkin or negedge rstn) begin
        if (!rstn) begin
          seed_q[gi] <= ONES;
        end else if (cfg_wr && (cfg_ch_i == CW'(gi))) begin
          seed_q[gi] <= (cfg_seed_i == '0) ? LENGTH'(1) : cfg_seed_i;
        end
      end

      // LFSR B: chip 0 is emitted straight from the seed on ARM, so load it pre-stepped.
      always_ff @(posedge clkin or negedge rstn) begin
        if (!rstn) begin
          b_q[gi] <= ONES;
        end else if (arm) begin
          b_q[gi] <= lfsr_step(seed_q[gi], POLY_B);
        end else if (run_tick) begin
          b_q[gi] <= lfsr_step(b_q[gi], POLY_B);
        end
      end

      // A starts all-ones, so chip 0 is simply the inverted seed MSB.
      assign gold_arm_d[gi]  = ~seed_q[gi][LENGTH-1];
      assign gold_tick_d[gi] = a_q[LENGTH-1] ^ b_q[gi][LENGTH-1];
    end
  endgenerate

  // Control FSM with registered outputs; also owns LFSR A, chip counter and divider.
  always_ff @(posedge clkin or negedge rstn) begin
    if (!rstn) begin
      state_q      <= S_IDLE;
      cfg_ready_o  <= 1'b1;
      code_gold_o  <= '0;
      code_valid_o <= 1'b0;
      epoch_o      <= 1'b0;
      chip_idx_o   <= '0;
      a_q          <= ONES;
      cnt_q        <= '0;
      div_q        <= '0;
      stop_pend_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          code_gold_o  <= '0;
          code_valid_o <= 1'b0;
          epoch_o      <= 1'b0;
          chip_idx_o   <= '0;
          stop_pend_q  <= 1'b0;
          cfg_ready_o  <= 1'b1;
          if (start_i) begin
            state_q     <= S_ARM;
            cfg_ready_o <= 1'b0;
          end
        end
        S_ARM: begin
          // Emit chip 0 here so the first valid lands two cycles after start.
          a_q          <= lfsr_step(ONES, POLY_A);
          code_gold_o  <= gold_arm_d;
          code_valid_o <= 1'b1;
          epoch_o      <= 1'b1;
          chip_idx_o   <= '0;
          cnt_q        <= (N > 1) ? LENGTH'(1) : '0;
          div_q        <= '0;
          stop_pend_q  <= 1'b0;
          state_q      <= S_RUN;
        end
        S_RUN: begin
          code_valid_o <= 1'b0;
          epoch_o      <= 1'b0;
          if (tick) begin
            a_q          <= lfsr_step(a_q, POLY_A);
            code_gold_o  <= gold_tick_d;
            code_valid_o <= 1'b1;
            epoch_o      <= (cnt_q == '0);
            chip_idx_o   <= cnt_q;
            cnt_q        <= (cnt_q == LENGTH'(N - 1)) ? '0 : cnt_q + LENGTH'(1);
            div_q        <= '0;
            if (stop_req) begin
              // This chip still goes out; the idle state clears outputs next cycle.
              state_q     <= S_IDLE;
              cfg_ready_o <= 1'b1;
              stop_pend_q <= 1'b0;
            end
          end else begin
            div_q <= div_q + DW'(1);
            if (stop_i) stop_pend_q <= 1'b1;
          end
        end
        default: begin
          state_q     <= S_IDLE;
          cfg_ready_o <= 1'b1;
        end
      endcase
    end
  end

`ifdef GOLD_PERIOD_CHECK_EN
  // LFSR A must be all-ones exactly when chip 0 is about to be emitted.
  always_ff @(posedge clkin or negedge rstn) begin
    if (!rstn) begin
      err_o <= 1'b0;
    end else if (run_tick && ((cnt_q == '0) != (a_q == ONES))) begin
      err_o <= 1'b1;
    end
  end
`else
  assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_gold_code_gen_mc.sv
// Self-checking bench for gold_code_gen_mc (3 channels, 4 clocks per chip).
module tb_gold_code_gen_mc;
  localparam int N    = 63;
  localparam int L    = 6;
  localparam int NCH  = 3;
  localparam int CDIV = 4;
  localparam logic [L-1:0] PA = 6'b100001;
  localparam logic [L-1:0] PB = 6'b110011;

  logic           clk = 1'b0;
  logic           rstn = 1'b0;
  logic           cfg_valid_i = 1'b0;
  logic           cfg_ready_o;
  logic [1:0]     cfg_ch_i = '0;
  logic [L-1:0]   cfg_seed_i = '0;
  logic           start_i = 1'b0;
  logic           stop_i = 1'b0;
  logic [NCH-1:0] code_gold_o;
  logic           code_valid_o;
  logic           epoch_o;
  logic [L-1:0]   chip_idx_o;
  logic           err_o;

  int errors = 0;
  int checks = 0;

  logic [L-1:0]   model_seed [NCH];
  logic [NCH-1:0] exp_word   [N];
  logic [NCH-1:0] cap        [2*N];

  gold_code_gen_mc #(.N(N), .POLY_A(PA), .POLY_B(PB), .NUM_CH(NCH), .CHIP_DIV(CDIV)) dut (
    .clkin(clk), .rstn(rstn),
    .cfg_valid_i(cfg_valid_i), .cfg_ready_o(cfg_ready_o),
    .cfg_ch_i(cfg_ch_i), .cfg_seed_i(cfg_seed_i),
    .start_i(start_i), .stop_i(stop_i),
    .code_gold_o(code_gold_o), .code_valid_o(code_valid_o),
    .epoch_o(epoch_o), .chip_idx_o(chip_idx_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [L-1:0] lfsr_next(input logic [L-1:0] s, input logic [L-1:0] p);
    return {s[L-2:0], ^(s & p)};
  endfunction

  // Full-period reference: each Gold chip i is m-sequence A[i] xor m-sequence B_k[i].
  function automatic void build_model();
    logic [L-1:0] a;
    logic [L-1:0] b [NCH];
    a = '1;
    for (int k = 0; k < NCH; k++) b[k] = (model_seed[k] == '0) ? 6'd1 : model_seed[k];
    for (int i = 0; i < N; i++) begin
      for (int k = 0; k < NCH; k++) begin
        exp_word[i][k] = a[L-1] ^ b[k][L-1];
        b[k] = lfsr_next(b[k], PB);
      end
      a = lfsr_next(a, PA);
    end
  endfunction

  task automatic cfg_write(input logic [1:0] ch, input logic [L-1:0] seed);
    @(negedge clk);
    cfg_valid_i = 1'b1; cfg_ch_i = ch; cfg_seed_i = seed;
    checks++;
    if (cfg_ready_o !== 1'b1) begin
      errors++; $display("FAIL cfg_ready_idle: got %b want 1", cfg_ready_o);
    end
    @(negedge clk);
    cfg_valid_i = 1'b0;
    if (ch < NCH) model_seed[ch] = seed;
    $display("cfg write ch=%0d seed=%h", ch, seed);
  endtask

  task automatic start_run(input bit with_stop);
    build_model();
    @(negedge clk);
    start_i = 1'b1; stop_i = with_stop;
    @(negedge clk);
    start_i = 1'b0; stop_i = 1'b0;
    checks++;
    if (code_valid_o !== 1'b0 || cfg_ready_o !== 1'b0) begin
      errors++;
      $display("FAIL arm_cycle: got valid=%b ready=%b want valid=0 ready=0", code_valid_o, cfg_ready_o);
    end
    $display("start (stop also high=%0d)", with_stop);
  endtask

  // Observes nchips chips of a run, raising stop so the last one is chip nchips-1.
  task automatic collect(input int nchips, input bit cfg_poke, input logic [L-1:0] poke_seed);
    int count;
    int cyc;
    int last_cyc;
    int budget;
    logic [NCH-1:0] last_gold;
    count = 0; cyc = 0; last_cyc = 0; last_gold = '0;
    budget = (nchips + 2) * CDIV + 8;
    while (count < nchips && cyc < budget) begin
      @(negedge clk);
      cyc++;
      if (code_valid_o === 1'b1) begin
        checks++;
        if (code_gold_o !== exp_word[count % N]) begin
          errors++; $display("FAIL gold chip%0d: got %b want %b", count, code_gold_o, exp_word[count % N]);
        end
        checks++;
        if (chip_idx_o !== 6'(count % N)) begin
          errors++; $display("FAIL chip_idx: got %0d want %0d", chip_idx_o, count % N);
        end
        checks++;
        if (epoch_o !== ((count % N) == 0)) begin
          errors++; $display("FAIL epoch chip%0d: got %b want %b", count, epoch_o, (count % N) == 0);
        end
        checks++;
        if (count == 0 && cyc != 1) begin
          errors++; $display("FAIL first_latency: got %0d want 1 cycles after arm", cyc);
        end else if (count > 0 && (cyc - last_cyc) != CDIV) begin
          errors++; $display("FAIL chip_gap: got %0d want %0d", cyc - last_cyc, CDIV);
        end
        if (count < 2 * N) cap[count] = code_gold_o;
        $display("chip %0d idx=%0d epoch=%b gold=%b", count, chip_idx_o, epoch_o, code_gold_o);
        last_gold = code_gold_o; last_cyc = cyc; count++;
        if (count == nchips - 1) stop_i = 1'b1;
        if (cfg_poke && count == 3) begin
          cfg_valid_i = 1'b1; cfg_ch_i = 2'd1; cfg_seed_i = poke_seed;
        end
        if (cfg_poke && count == 5) cfg_valid_i = 1'b0;
      end else if (count > 0) begin
        checks++;
        if (code_gold_o !== last_gold || chip_idx_o !== 6'((count - 1) % N) || cfg_ready_o !== 1'b0) begin
          errors++;
          $display("FAIL hold: got gold=%b idx=%0d ready=%b want gold=%b idx=%0d ready=0",
                   code_gold_o, chip_idx_o, cfg_ready_o, last_gold, (count - 1) % N);
        end
      end
    end
    stop_i = 1'b0; cfg_valid_i = 1'b0;
    checks++;
    if (count < nchips) begin
      errors++; $display("FAIL chip_timeout: got %0d chips want %0d", count, nchips);
    end
    @(negedge clk);
    checks++;
    if (code_valid_o !== 1'b0 || code_gold_o !== '0 || chip_idx_o !== '0 || epoch_o !== 1'b0 || cfg_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL idle_outputs: got valid=%b gold=%b idx=%0d epoch=%b ready=%b want 0 0 0 0 1",
               code_valid_o, code_gold_o, chip_idx_o, epoch_o, cfg_ready_o);
    end
    for (int i = 0; i < 2 * CDIV; i++) begin
      @(negedge clk);
      checks++;
      if (code_valid_o !== 1'b0) begin
        errors++; $display("FAIL valid_after_stop: got 1 want 0");
      end
    end
    checks++;
    if (err_o !== 1'b0) begin
      errors++; $display("FAIL err_clean: got %b want 0", err_o);
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    for (int k = 0; k < NCH; k++) model_seed[k] = '1;
    repeat (3) @(negedge clk);
    checks++;
    if (cfg_ready_o !== 1'b1 || code_valid_o !== 1'b0 || code_gold_o !== '0 ||
        epoch_o !== 1'b0 || chip_idx_o !== '0 || err_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_values: got ready=%b valid=%b gold=%b epoch=%b idx=%0d err=%b want 1 0 0 0 0 0",
               cfg_ready_o, code_valid_o, code_gold_o, epoch_o, chip_idx_o, err_o);
    end
    rstn = 1'b1;
    $display("reset released");
  endtask

  // Default seeds, start and stop raised together; run past one full period.
  task automatic test_default_run();
    start_run(1'b1);
    checks++;
    if (exp_word[0] !== '0) begin
      errors++; $display("FAIL model_chip0: got %b want 0", exp_word[0]);
    end
    collect(N + 1, 1'b0, '0);
  endtask

  task automatic test_gold_correlation();
    int bad0;
    int bad1;
    int bad2;
    int dup;
    int sum;
    cfg_write(2'd0, 6'h01);
    cfg_write(2'd1, 6'h2A);
    cfg_write(2'd2, 6'h00);
    cfg_write(2'd3, 6'h15);
    start_run(1'b0);
    collect(2 * N, 1'b0, '0);
    bad0 = 0; bad1 = 0; bad2 = 0; dup = 0;
    for (int i = 0; i < N; i++) begin
      if (cap[i][0] !== cap[i+N][0]) bad0++;
      if (cap[i][1] !== cap[i+N][1]) bad1++;
      if (cap[i][2] !== cap[i+N][2]) bad2++;
      if (cap[i][2] !== cap[i][0]) dup++;
    end
    checks++;
    if (bad0 + bad1 + bad2 != 0) begin
      errors++; $display("FAIL period63: got %0d/%0d/%0d mismatches want 0", bad0, bad1, bad2);
    end
    checks++;
    if (dup != 0) begin
      errors++; $display("FAIL zero_seed_ch2: got %0d differing chips want 0", dup);
    end
    for (int lag = 0; lag < N; lag++) begin
      sum = 0;
      for (int i = 0; i < N; i++) sum += (cap[i][0] ^ cap[(i + lag) % N][1]) ? -1 : 1;
      checks++;
      if (sum != -1 && sum != -17 && sum != 15) begin
        errors++; $display("FAIL xcorr lag%0d: got %0d want -1/-17/15", lag, sum);
      end
    end
    $display("correlation run done");
  endtask

  task automatic test_cfg_during_run();
    start_run(1'b0);
    collect(12, 1'b1, 6'h15);
    cfg_write(2'd1, 6'h15);
    start_run(1'b0);
    collect(20, 1'b0, '0);
  endtask

  // Stop at chip 10, then restart: chip 0 onward must match the first run.
  task automatic test_stop_restart();
    start_run(1'b0);
    collect(11, 1'b0, '0);
    start_run(1'b0);
    collect(16, 1'b0, '0);
  endtask

  task automatic test_random_seeds();
    for (int it = 0; it < 3; it++) begin
      for (int w = 0; w < 3; w++) cfg_write(2'($urandom_range(0, 3)), 6'($urandom_range(0, 63)));
      start_run(1'($urandom_range(0, 1)));
      collect(int'($urandom_range(5, 70)), 1'b0, '0);
    end
  endtask

  task automatic test_reset_midrun();
    cfg_write(2'd0, 6'h07);
    start_run(1'b0);
    repeat (25) @(negedge clk);
    #2 rstn = 1'b0;
    #1;
    checks++;
    if (cfg_ready_o !== 1'b1 || code_valid_o !== 1'b0 || code_gold_o !== '0 || chip_idx_o !== '0) begin
      errors++;
      $display("FAIL async_reset: got ready=%b valid=%b gold=%b idx=%0d want 1 0 0 0",
               cfg_ready_o, code_valid_o, code_gold_o, chip_idx_o);
    end
    for (int k = 0; k < NCH; k++) model_seed[k] = '1;
    @(negedge clk);
    rstn = 1'b1;
    $display("mid-run reset applied");
    start_run(1'b0);
    collect(8, 1'b0, '0);
  endtask

`ifdef GOLD_PERIOD_CHECK_EN
  task automatic test_period_check();
    int waited;
    start_run(1'b0);
    repeat (30) @(negedge clk);
    checks++;
    if (err_o !== 1'b0) begin
      errors++; $display("FAIL err_before_force: got %b want 0", err_o);
    end
    force dut.a_q = 6'h15;
    @(negedge clk);
    release dut.a_q;
    waited = 0;
    while (err_o !== 1'b1 && waited < 2 * N * CDIV + 10) begin
      @(negedge clk); waited++;
    end
    checks++;
    if (err_o !== 1'b1) begin
      errors++; $display("FAIL err_set: got %b want 1", err_o);
    end
    stop_i = 1'b1;
    repeat (3 * CDIV) @(negedge clk);
    stop_i = 1'b0;
    checks++;
    if (err_o !== 1'b1) begin
      errors++; $display("FAIL err_sticky: got %b want 1", err_o);
    end
    #2 rstn = 1'b0;
    #1;
    checks++;
    if (err_o !== 1'b0) begin
      errors++; $display("FAIL err_clear: got %b want 0", err_o);
    end
    @(negedge clk);
    rstn = 1'b1;
    for (int k = 0; k < NCH; k++) model_seed[k] = '1;
    $display("period check exercised");
  endtask
`endif

  initial begin
    test_reset();
    test_default_run();
    test_gold_correlation();
    test_cfg_during_run();
    test_stop_restart();
    test_random_seeds();
    test_reset_midrun();
`ifdef GOLD_PERIOD_CHECK_EN
    test_period_check();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/gold_code_gen_mc.md
# gold_code_gen_mc

Parametrised multi-channel Gold code generator, successor to the single-channel Gold generator and shift-register generator pair. One shared m-sequence LFSR A is combined with NUM_CH independently seeded LFSR B instances to produce NUM_CH Gold codes chip-aligned on a common epoch. Per-channel seeds arrive over a valid/ready config handshake while idle. Runs a start/stop-controlled chip stream at a programmable chip rate, on the PLL-derived system clock.

## Interface
- N, 63, code period in chips; must equal 2^LENGTH-1
- LENGTH, $clog2(N+1), LFSR degree
- POLY_A, 6'b100001, LFSR A tap mask (x^6+x+1)
- POLY_B, 6'b110011, LFSR B tap mask (x^6+x^5+x^2+x+1); must form a preferred pair with POLY_A
- NUM_CH, 4, number of Gold code channels (1..16)
- CHIP_DIV, 1, clock cycles per chip (1..256)
- clkin  in  1  system clock
- rstn  in  1  asynchronous active-low reset
- cfg_valid_i  in  1  seed write request
- cfg_ready_o  out  1  seed write accepted when high with cfg_valid_i
- cfg_ch_i  in  max(1,$clog2(NUM_CH))  target channel
- cfg_seed_i  in  LENGTH  LFSR B seed for that channel
- start_i  in  1  start request (level sampled)
- stop_i  in  1  stop request (level sampled)
- code_gold_o  out  NUM_CH  current chip per channel
- code_valid_o  out  1  one-cycle pulse per new chip
- epoch_o  out  1  high with code_valid_o on chip 0
- chip_idx_o  out  LENGTH  index of current chip, 0..N-1
- err_o  out  1  sticky period-check error

## Operation
- LFSR: Fibonacci, shift toward MSB; feedback into bit 0 = XOR of (state & POLY); chip output = state[LENGTH-1] before shift.
- Seed RAM: NUM_CH x LENGTH registers, reset to all-ones. Seed 0 stored as 1 (avoids lock-up). cfg_ch_i >= NUM_CH: handshake completes, write dropped.
- FSM states: IDLE, ARM, RUN.
  - IDLE: cfg_ready_o=1. start_i=1 -> ARM. stop_i ignored.
  - ARM (1 cycle): A <= all-ones, each B[k] <= seed[k], chip counter <= 0, divider <= 0 -> RUN.
  - RUN: cfg_ready_o=0. Each chip tick: code_gold_o[k] <= A[MSB]^B[k][MSB], all LFSRs step, chip_idx_o <= counter, counter wraps N-1 -> 0. start_i ignored. stop_i=1 -> IDLE at next tick boundary (chip in progress completes, no further valid).
- Entering IDLE: code_gold_o, chip_idx_o <= 0; code_valid_o, epoch_o low.

## Timing
- Reset values: cfg_ready_o=1 (state IDLE), all other outputs 0, seeds all-ones, err_o 0.
- start_i sampled high at edge t: ARM during cycle t+1; first code_valid_o (chip 0, epoch_o=1) in cycle t+2; subsequent every CHIP_DIV cycles.
- All outputs registered; code_gold_o/chip_idx_o hold between pulses.
- start_i and stop_i both high in IDLE: start wins. stop_i high on a tick cycle: that chip is emitted, then IDLE next cycle.
- Config write takes effect at next ARM; never mid-run.
- rstn low mid-run: immediate return to reset values, seeds reset.

## Configuration
- GOLD_PERIOD_CHECK_EN defined: checker compares LFSR A state to all-ones whenever the chip counter wraps to 0; mismatch (or all-ones at any other index) sets err_o until reset.
- Undefined: checker absent, err_o tied 0.

## Test plan
- Reset, start with default seeds -> first valid 2 cycles after start, epoch_o=1, chip_idx_o=0, all code_gold_o bits 0 (identical A/B all-ones MSB); epoch repeats every 63 chips.
- Seeds ch0=6'h01, ch1=6'h2A, 2 full periods -> each channel period 63; periodic cross-correlation ch0 vs ch1 in {-1,-17,15} at every lag.
- cfg_seed_i=0 to ch2 -> ch2 output identical to channel seeded 6'h01.
- cfg_valid_i during RUN -> cfg_ready_o=0, no write; after stop, write accepted and applied on next start.
- CHIP_DIV=4, stop_i at chip 10 -> last valid is chip 10, IDLE, outputs 0; restart -> chip 0 sequence identical to first run.
- GOLD_PERIOD_CHECK_EN on, force A state mid-run -> err_o=1 at next wrap, sticky; rstn pulse clears.
